// File: rtl/mac_nbit_pipe.sv
// mac_nbit_pipe: two-stage pipelined N-bit multiply-accumulate with windowed, saturating output.
// Define MAC_OUT_REG_EN to register MAC_OUT/MAC_OUT_VALID (3-edge latency); default is combinational (2-edge).
module mac_nbit_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_GUARD  = 4,
  parameter int SEL_WIDTH  = 6
) (
  input  logic                  MAC_ACC_CLK,
  input  logic                  acc_ff_rstn,
  input  logic                  EFPGA_MATHB_CLK_EN,
  input  logic                  MAC_IN_VALID,
  input  logic [DATA_WIDTH-1:0] MAC_OPER_DATA,
  input  logic [DATA_WIDTH-1:0] MAC_COEF_DATA,
  input  logic                  MAC_TC,
  input  logic                  MAC_ACC_CLEAR,
  input  logic                  MAC_ACC_RND,
  input  logic                  MAC_ACC_SAT,
  input  logic [SEL_WIDTH-1:0]  MAC_OUT_SEL,
  output logic [DATA_WIDTH-1:0] MAC_OUT,
  output logic                  MAC_OUT_VALID,
  output logic                  MAC_ACC_OVF,
  output logic                  MAC_SAT_FLAG
);
  localparam int AW = 2*DATA_WIDTH + ACC_GUARD;
  localparam int XW = AW - DATA_WIDTH;
  localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(XW);

  logic [AW-1:0]         w_a, w_b, w_prod, w_rnd, w_base, w_hi_s, w_hi_u;
  logic [AW:0]           w_sum;
  logic                  w_ovf, w_clr_flags, w_over;
  logic [SEL_WIDTH-1:0]  w_sel;
  logic [DATA_WIDTH-1:0] w_win, w_sat_val, w_out;

  logic                  r1_vld, r1_tc, r1_clr, r1_rnd, r1_sat;
  logic [AW-1:0]         r1_prod;
  logic [SEL_WIDTH-1:0]  r1_sel;
  logic                  r2_vld, r2_tc, r2_sat, r_ovf, r_satf;
  logic [AW-1:0]         r_acc;
  logic [SEL_WIDTH-1:0]  r2_sel;

  assign w_a    = MAC_TC ? {{XW{MAC_OPER_DATA[DATA_WIDTH-1]}}, MAC_OPER_DATA} : {{XW{1'b0}}, MAC_OPER_DATA};
  assign w_b    = MAC_TC ? {{XW{MAC_COEF_DATA[DATA_WIDTH-1]}}, MAC_COEF_DATA} : {{XW{1'b0}}, MAC_COEF_DATA};
  assign w_prod = w_a * w_b;

  assign w_rnd       = (r1_sel != '0 && r1_sel <= MAX_SEL) ? (AW'(1) << (r1_sel - 1'b1)) : '0;
  assign w_base      = r1_clr ? '0 : r1_rnd ? w_rnd : r_acc;
  assign w_sum       = {1'b0, w_base} + {1'b0, r1_prod};
  assign w_ovf       = r1_tc ? (w_base[AW-1] == r1_prod[AW-1]) && (w_sum[AW-1] != w_base[AW-1]) : w_sum[AW];
  assign w_clr_flags = r1_vld & r1_clr & ~w_ovf;

  assign w_sel     = (r2_sel > MAX_SEL) ? '0 : r2_sel;
  assign w_win     = DATA_WIDTH'(r_acc >> w_sel);
  assign w_hi_s    = AW'($signed(r_acc) >>> (32'(w_sel) + DATA_WIDTH - 1));
  assign w_hi_u    = r_acc >> (32'(w_sel) + DATA_WIDTH);
  assign w_over    = r2_tc ? ~(&w_hi_s | ~|w_hi_s) : |w_hi_u;
  assign w_sat_val = r2_tc ? (r_acc[AW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}})
                           : {DATA_WIDTH{1'b1}};
  assign w_out     = (r2_sat & w_over) ? w_sat_val : w_win;

  // Stage 1: capture the extended product with its per-operation controls
  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      r1_vld  <= 1'b0;
      r1_prod <= '0;
      r1_tc   <= 1'b0;
      r1_clr  <= 1'b0;
      r1_rnd  <= 1'b0;
      r1_sat  <= 1'b0;
      r1_sel  <= '0;
    end else if (EFPGA_MATHB_CLK_EN) begin
      r1_vld  <= MAC_IN_VALID;
      r1_prod <= w_prod;
      r1_tc   <= MAC_TC;
      r1_clr  <= MAC_ACC_CLEAR;
      r1_rnd  <= MAC_ACC_RND;
      r1_sat  <= MAC_ACC_SAT;
      r1_sel  <= MAC_OUT_SEL;
    end
  end

  // Stage 2: accumulate valid products and maintain the sticky flags
  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      r2_vld <= 1'b0;
      r_acc  <= '0;
      r2_sel <= '0;
      r2_sat <= 1'b0;
      r2_tc  <= 1'b0;
      r_ovf  <= 1'b0;
      r_satf <= 1'b0;
    end else if (EFPGA_MATHB_CLK_EN) begin
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r_acc  <= w_sum[AW-1:0];
        r2_sel <= r1_sel;
        r2_sat <= r1_sat;
        r2_tc  <= r1_tc;
        r_ovf  <= (r1_clr ? 1'b0 : r_ovf) | w_ovf;
      end
      r_satf <= (w_clr_flags ? 1'b0 : r_satf) | (r2_vld & r2_sat & w_over);
    end
  end

  assign MAC_ACC_OVF  = r_ovf;
  assign MAC_SAT_FLAG = r_satf;

`ifdef MAC_OUT_REG_EN
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_out_vld;
  // Optional output register stage adding one edge of latency to the data path
  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else if (EFPGA_MATHB_CLK_EN) begin
      r_out     <= w_out;
      r_out_vld <= r2_vld;
    end
  end
  assign MAC_OUT       = r_out;
  assign MAC_OUT_VALID = r_out_vld;
`else
  assign MAC_OUT       = w_out;
  assign MAC_OUT_VALID = r2_vld;
`endif
endmodule

// File: tb/tb_mac_nbit_pipe.sv
// tb_mac_nbit_pipe: directed self-checking bench for mac_nbit_pipe (DATA_WIDTH=8, ACC_WIDTH=20).
module tb_mac_nbit_pipe;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       en = 1'b1;
  logic       vld = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       tc = 1'b0, clr = 1'b0, rnd = 1'b0, sat = 1'b0;
  logic [5:0] sel = '0;
  logic [7:0] out;
  logic       out_vld, ovf, satf;
  int checks = 0;
  int failures = 0;

  mac_nbit_pipe #(.DATA_WIDTH(8), .ACC_GUARD(4), .SEL_WIDTH(6)) dut (
    .MAC_ACC_CLK(clk), .acc_ff_rstn(rstn), .EFPGA_MATHB_CLK_EN(en),
    .MAC_IN_VALID(vld), .MAC_OPER_DATA(a), .MAC_COEF_DATA(b), .MAC_TC(tc),
    .MAC_ACC_CLEAR(clr), .MAC_ACC_RND(rnd), .MAC_ACC_SAT(sat), .MAC_OUT_SEL(sel),
    .MAC_OUT(out), .MAC_OUT_VALID(out_vld), .MAC_ACC_OVF(ovf), .MAC_SAT_FLAG(satf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] ia, input logic [7:0] ib, input logic itc,
                       input logic iclr, input logic irnd, input logic isat, input logic [5:0] isel);
    vld = v; a = ia; b = ib; tc = itc; clr = iclr; rnd = irnd; sat = isat; sel = isel;
  endtask

  initial begin
    #1 rstn = 1'b0;
    #1;
    chk("rst_out", 32'(out), 0);
    chk("rst_vld", 32'(out_vld), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_satf", 32'(satf), 0);
    tick(); tick();
    #3 rstn = 1'b1;

    drive(1, 8'h0F, 8'h0F, 0, 1, 0, 0, 0);
    tick(); chk("s1_lat_vld", 32'(out_vld), 0);
    drive(1, 8'h0F, 8'h0F, 0, 0, 0, 0, 0);
    tick(); chk("s1_vld1", 32'(out_vld), 1); chk("s1_acc1", 32'(out), 32'hE1);
    tick(); chk("s1_acc2", 32'(out), 32'hC2);
    tick(); chk("s1_acc3", 32'(out), 32'hA3);
    vld = 0;
    tick(); chk("s1_acc4", 32'(out), 32'h84); chk("s1_vld4", 32'(out_vld), 1);
    tick(); chk("s1_vld_drop", 32'(out_vld), 0); chk("s1_out_hold", 32'(out), 32'h84);
    chk("s1_satf", 32'(satf), 0);

    drive(1, 8'h0F, 8'h0F, 0, 1, 0, 1, 0);
    tick();
    drive(1, 8'h0F, 8'h0F, 0, 0, 0, 1, 0);
    tick(); chk("s2_nosat", 32'(out), 32'hE1);
    tick(); chk("s2_sat2", 32'(out), 32'hFF);
    tick(); vld = 0;
    tick(); chk("s2_sat4", 32'(out), 32'hFF);
    tick(); chk("s2_satf", 32'(satf), 1);
    drive(1, 8'h00, 8'h00, 0, 0, 0, 1, 2);
    tick(); vld = 0;
    tick(); chk("s2_sel2", 32'(out), 32'hE1);

    drive(1, 8'h80, 8'h7F, 1, 1, 0, 1, 7);
    tick(); vld = 0;
    tick(); chk("s3_win1", 32'(out), 32'h81);
    tick(); chk("s3_satf_clr", 32'(satf), 0); chk("s3_ovf1", 32'(ovf), 0);
    drive(1, 8'h80, 8'h7F, 1, 0, 0, 1, 7);
    tick(); vld = 0;
    tick(); chk("s3_sat_neg", 32'(out), 32'h80);
    tick(); chk("s3_satf", 32'(satf), 1);
    drive(1, 8'h00, 8'h00, 1, 0, 0, 0, 7);
    tick(); vld = 0;
    tick(); chk("s3_wrap_win", 32'(out), 32'h02);

    drive(1, 8'h01, 8'h08, 0, 1, 0, 0, 4);
    tick(); vld = 0;
    tick(); chk("s4_nornd", 32'(out), 32'h00);
    drive(1, 8'h01, 8'h08, 0, 0, 1, 0, 4);
    tick(); vld = 0;
    tick(); chk("s4_rnd", 32'(out), 32'h01);
    chk("s4_satf_clr", 32'(satf), 0);

    drive(1, 8'hFF, 8'hFF, 0, 1, 0, 0, 0);
    tick();
    clr = 0;
    repeat (15) tick();
    chk("s5_ovf_pre", 32'(ovf), 0);
    tick(); vld = 0;
    tick(); chk("s5_ovf_set", 32'(ovf), 1); chk("s5_wrap_out", 32'(out), 32'h11);
    drive(1, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    tick(); vld = 0;
    tick(); chk("s5_ovf_sticky", 32'(ovf), 1);
    drive(1, 8'h00, 8'h00, 0, 1, 0, 0, 0);
    tick(); vld = 0;
    tick(); chk("s5_ovf_clr", 32'(ovf), 0); chk("s5_out0", 32'(out), 0);

    drive(1, 8'h03, 8'h05, 0, 1, 0, 0, 0);
    tick();
    drive(1, 8'h02, 8'h02, 0, 0, 0, 0, 0);
    tick(); vld = 0; en = 0;
    chk("s6_pre_out", 32'(out), 32'h0F);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s6_stall_vld", 32'(out_vld), 1);
      chk("s6_stall_out", 32'(out), 32'h0F);
    end
    en = 1;
    tick(); chk("s6_resume_vld", 32'(out_vld), 1); chk("s6_resume_out", 32'(out), 32'h13);
    tick(); chk("s6_resume_drop", 32'(out_vld), 0);
    drive(1, 8'h07, 8'h07, 0, 0, 0, 0, 0);
    tick(); vld = 0;
    tick(); chk("s6_last_out", 32'(out), 32'h44);
    #2 rstn = 1'b0;
    #1;
    chk("s6_async_out", 32'(out), 0);
    chk("s6_async_vld", 32'(out_vld), 0);
    #2 rstn = 1'b1;
    tick(); chk("s6_post_vld", 32'(out_vld), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
